// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Optional checksum support is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

    localparam int IMEM_ADDR_W    = 15;
    localparam int IMEM_DATA_W    = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian stream bytes into instruction words.
// word/word_full describe the word completed by the byte taken this cycle.
module byte_packer
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              take,
    input  logic [7:0]        din,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] sr;
    logic [1:0]        idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (clr) begin
            sr  <= '0;
            idx <= '0;
        end else if (take) begin
            sr  <= {din, sr[DATA_W-1:8]};
            idx <= idx + 2'd1;
        end
    end

    // Bytes enter at the top lane, so after the fourth byte lane 0 holds byte 0.
    assign word_full = take && (idx == 2'(BYTES_PER_WORD - 1));
    assign word      = {din, sr[DATA_W-1:8]};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction BRAM write port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [63:0]       MAX_WORDS = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FIN = ST_CHECK;
    logic [7:0] csum;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    state_t      state, nstate;
    logic [15:0] len;
    logic [15:0] len_in;
    logic        take;
    logic        last_word;
    logic        pk_full;
    logic [DATA_W-1:0] pk_word;

    assign take      = in_valid && in_ready;
    assign len_in    = {in_data, len[7:0]};
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state == ST_IDLE) && start),
        .take      (take && (state == ST_DATA)),
        .din       (in_data),
        .word_full (pk_full),
        .word      (pk_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   if (start) nstate = ST_LEN_LO;
            ST_LEN_LO: if (take) nstate = ST_LEN_HI;
            ST_LEN_HI: if (take) begin
                if (len_in == 16'd0)               nstate = ST_FIN;
                else if (64'(len_in) > MAX_WORDS)  nstate = ST_ERR;
                else                               nstate = ST_DATA;
            end
            ST_DATA:   if (pk_full) nstate = ST_WRITE;
            ST_WRITE:  nstate = last_word ? ST_FIN : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK:  if (take) nstate = (in_data == csum) ? ST_DONE : ST_ERR;
`endif
            ST_DONE:   nstate = ST_IDLE;
            ST_ERR:    nstate = ST_IDLE;
            default:   nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            mem_addr <= BASE;
            mem_din  <= '0;
            word_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                word_cnt <= '0;
                mem_addr <= BASE;
            end
            if (take && (state == ST_LEN_LO)) len[7:0]  <= in_data;
            if (take && (state == ST_LEN_HI)) len[15:8] <= in_data;
            if (pk_full) mem_din <= pk_word;
            // Address saturates at the top of memory instead of wrapping to 0.
            if (state == ST_WRITE) begin
                word_cnt <= word_cnt + CNT_ONE;
                if (mem_addr != '1) mem_addr <= mem_addr + ADDR_ONE;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 csum <= '0;
        else if ((state == ST_IDLE) && start)    csum <= '0;
        else if (take && (state != ST_CHECK))    csum <= csum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a frame-level model.
// Follows IMEM_LOADER_CHECKSUM_EN to decide whether frames carry a checksum.
module tb_imem_loader;

    localparam int AW   = 15;
    localparam int BASE = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready;
    logic [7:0]    in_data;
    logic          mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [AW:0]   word_cnt;

    int  errors = 0;
    int  checks = 0;
    int  done_seen = 0;
    int  err_seen = 0;
    int  max_gap = 0;
    wr_t exp_q[$];
    wr_t log_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .DATA_W(32), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write must match the next word the model expects, in order.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_we) begin
                wr_t w;
                w.a = mem_addr;
                w.d = mem_din;
                log_q.push_back(w);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_din);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.a));
                    chk("wr_data", 64'(mem_din), 64'(e.d));
                end
            end
            if (done) done_seen++;
            if (err)  err_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        int gap;
        gap = $urandom_range(0, max_gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Frame-level model: words land at BASE+i, little-endian, outcome from length/checksum rules.
    task automatic run_frame(input int len, input logic [7:0] pay[$], input bit good_csum, input int mid_start_at);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit oversize, exp_ok;
        int nwords, n;
        oversize = len > ((1 << AW) - BASE);
        nwords   = oversize ? 0 : len;
        exp_ok   = !oversize && (!CSUM || good_csum);
        bytes.push_back(8'(len));
        bytes.push_back(8'(len >> 8));
        x = 8'(len) ^ 8'(len >> 8);
        for (int i = 0; i < nwords; i++) begin
            wr_t w;
            w.a = AW'(BASE + i);
            w.d = 32'(pay[4*i]) + (32'(pay[4*i+1]) << 8) + (32'(pay[4*i+2]) << 16) + (32'(pay[4*i+3]) << 24);
            exp_q.push_back(w);
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(pay[4*i+k]);
                x = x ^ pay[4*i+k];
            end
        end
        if (CSUM && !oversize) bytes.push_back(good_csum ? x : (x ^ 8'h5a));

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("word_cnt_after_start", 64'(word_cnt), 64'(0));
        chk("in_ready_len", 64'(in_ready), 64'(1));

        for (int k = 0; k < bytes.size(); k++) begin
            if (k == mid_start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(bytes[k]);
        end

        n = 0;
        while (!(done || err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no done/err expected one within 40 cycles");
        end
        chk("done", 64'(done), 64'(exp_ok));
        chk("err", 64'(err), 64'(!exp_ok));
        chk("busy_end", 64'(busy), 64'(0));
        chk("word_cnt_end", 64'(word_cnt), 64'(nwords));
        @(negedge clk);
        chk("pending_writes", 64'(exp_q.size()), 64'(0));
        chk("word_cnt_hold", 64'(word_cnt), 64'(nwords));
        chk("idle_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of run expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pay[$];
        int e0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done_err", 64'({done, err}), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(BASE));
        chk("rst_mem_din", 64'(mem_din), 64'(0));
        chk("rst_word_cnt", 64'(word_cnt), 64'(0));
        rst = 1'b0;

        // A pending byte in IDLE must not be taken.
        in_valid = 1'b1;
        in_data  = 8'hee;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_accept", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;

        // Basic two-word image, also pinned with literal values.
        max_gap = 0;
        log_q.delete();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame(2, pay, 1'b1, -1);
        if (log_q.size() < 2) begin
            checks++;
            errors++;
            $display("FAIL basic_write_count: got %0d expected 2", log_q.size());
        end else begin
            chk("basic_addr0", 64'(log_q[0].a), 64'(0));
            chk("basic_data0", 64'(log_q[0].d), 64'h00000013);
            chk("basic_addr1", 64'(log_q[1].a), 64'(1));
            chk("basic_data1", 64'(log_q[1].d), 64'h00100093);
        end
        chk("basic_word_cnt", 64'(word_cnt), 64'(2));

        pay.delete();
        run_frame(0, pay, 1'b1, -1);
        if (CSUM) run_frame(0, pay, 1'b0, -1);

        // Oversize length 32769 is rejected with no writes.
        run_frame(32769, pay, 1'b1, -1);

        // Randomised frames with gaps, bad checksums and start pulses mid-frame.
        for (int f = 0; f < 8; f++) begin
            int len;
            int ms;
            len     = $urandom_range(1, 6);
            max_gap = $urandom_range(0, 3);
            pay.delete();
            for (int i = 0; i < 4 * len; i++) pay.push_back(8'($urandom));
            ms = (f % 2 == 0) ? $urandom_range(3, 1 + 4 * len) : -1;
            run_frame(len, pay, ($urandom_range(0, 3) != 0), ms);
        end

        // Length 32768 is legal; reset mid-frame after two payload bytes.
        max_gap = 1;
        e0 = err_seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00);
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        chk("maxlen_no_err", 64'(err_seen), 64'(e0));
        chk("maxlen_busy", 64'(busy), 64'(1));
        chk("maxlen_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 64'({in_ready, mem_we, busy, done, err}), 64'(0));
        chk("midrst_addr", 64'(mem_addr), 64'(BASE));
        chk("midrst_word_cnt", 64'(word_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        pay = '{8'hb7, 8'h02, 8'h01, 8'h00};
        run_frame(1, pay, 1'b1, -1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
